// File: rtl/nv_fifo_ctl_20x16.sv
`timescale 1ns/1ps
// FIFO controller driving an external 20x16 registered-read RAM with a two-stage read pipeline.
// Optional write-to-output bypass: define NV_FIFO_CTL_BYPASS_EN.
module nv_fifo_ctl_20x16 #(
    parameter int DEPTH = 20,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_pvld,
    output logic             wr_prdy,
    input  logic [WIDTH-1:0] wr_pd,
    output logic             rd_pvld,
    input  logic             rd_prdy,
    output logic [WIDTH-1:0] rd_pd,
    output logic [4:0]       occ,
    output logic [4:0]       ram_wa,
    output logic [4:0]       ram_ra,
    output logic             ram_we,
    output logic             ram_re,
    output logic             ram_ore,
    output logic             ram_byp_sel,
    output logic [WIDTH-1:0] ram_di,
    output logic [WIDTH-1:0] ram_dbyp,
    input  logic [WIDTH-1:0] ram_dout,
    input  logic [31:0]      pwrbus_ram_pd,
    output logic [31:0]      ram_pwrbus_pd
);

    localparam logic [4:0] DEPTH_C = 5'(DEPTH);
    localparam logic [4:0] LAST_C  = 5'(DEPTH - 1);

    logic [4:0] wr_ptr_q, wr_ptr_d;
    logic [4:0] rd_ptr_q, rd_ptr_d;
    logic [4:0] cnt_q, cnt_d;
    logic       s1_vld_q, s1_vld_d;
    logic       s2_vld_q, s2_vld_d;
    logic       bypass_take;

    // Handshake and RAM strobes; every strobe is forced low while rst is high.
    always_comb begin
        wr_prdy = (cnt_q < DEPTH_C) & ~rst;
`ifdef NV_FIFO_CTL_BYPASS_EN
        // An empty pipeline whose output slot frees this cycle lets the word skip the RAM.
        bypass_take = wr_pvld & (cnt_q == '0) & ~s1_vld_q & (~s2_vld_q | rd_prdy) & ~rst;
        ram_byp_sel = bypass_take;
        ram_dbyp    = wr_pd;
`else
        bypass_take = 1'b0;
        ram_byp_sel = 1'b0;
        ram_dbyp    = '0;
`endif
        ram_we  = wr_pvld & wr_prdy & ~bypass_take;
        ram_ore = (s1_vld_q | bypass_take) & (~s2_vld_q | rd_prdy) & ~rst;
        // cnt_q is registered, so a word written this cycle cannot be read before the next.
        ram_re  = (cnt_q != '0) & (~s1_vld_q | ram_ore) & ~rst;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (ram_we) begin
            wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 5'd1;
        end
        if (ram_re) begin
            rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 5'd1;
        end
        cnt_d    = cnt_q + {4'd0, ram_we} - {4'd0, ram_re};
        s1_vld_d = ram_re | (s1_vld_q & ~ram_ore);
        s2_vld_d = ram_ore | (s2_vld_q & ~rd_prdy);
    end

    // NOTE: state flops use non-blocking assignments; the RAM array and its output
    // register live outside this block and need no reset because s2_vld qualifies rd_pd.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
        end
    end

    always_comb begin
        ram_wa        = wr_ptr_q;
        ram_ra        = rd_ptr_q;
        ram_di        = wr_pd;
        rd_pvld       = s2_vld_q;
        rd_pd         = ram_dout;
        occ           = cnt_q + {4'd0, s1_vld_q} + {4'd0, s2_vld_q};
        ram_pwrbus_pd = pwrbus_ram_pd;
    end

endmodule

// File: tb/tb_nv_fifo_ctl_20x16.sv
`timescale 1ns/1ps
// Self-checking bench for nv_fifo_ctl_20x16: external RAM model, queue scoreboard,
// directed latency/fill/stream/reset/bypass steps plus a randomized phase.
module tb_nv_fifo_ctl_20x16;

    logic        clk;
    logic        rst;
    logic        wr_pvld;
    logic        wr_prdy;
    logic [15:0] wr_pd;
    logic        rd_pvld;
    logic        rd_prdy;
    logic [15:0] rd_pd;
    logic [4:0]  occ;
    logic [4:0]  ram_wa;
    logic [4:0]  ram_ra;
    logic        ram_we;
    logic        ram_re;
    logic        ram_ore;
    logic        ram_byp_sel;
    logic [15:0] ram_di;
    logic [15:0] ram_dbyp;
    logic [15:0] ram_dout;
    logic [31:0] pwrbus_ram_pd;
    logic [31:0] ram_pwrbus_pd;

    nv_fifo_ctl_20x16 #(.DEPTH(20), .WIDTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_pvld       (wr_pvld),
        .wr_prdy       (wr_prdy),
        .wr_pd         (wr_pd),
        .rd_pvld       (rd_pvld),
        .rd_prdy       (rd_prdy),
        .rd_pd         (rd_pd),
        .occ           (occ),
        .ram_wa        (ram_wa),
        .ram_ra        (ram_ra),
        .ram_we        (ram_we),
        .ram_re        (ram_re),
        .ram_ore       (ram_ore),
        .ram_byp_sel   (ram_byp_sel),
        .ram_di        (ram_di),
        .ram_dbyp      (ram_dbyp),
        .ram_dout      (ram_dout),
        .pwrbus_ram_pd (pwrbus_ram_pd),
        .ram_pwrbus_pd (ram_pwrbus_pd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 20x16 RAM: re captures the addressed word, ore loads the output register.
    logic [15:0] mem [0:19];
    logic [15:0] ram_s1_data;
    always @(posedge clk) begin
        if (ram_we && ram_wa < 5'd20) mem[ram_wa] <= ram_di;
        if (ram_re && ram_ra < 5'd20) ram_s1_data <= mem[ram_ra];
        if (ram_ore) ram_dout <= ram_byp_sel ? ram_dbyp : ram_s1_data;
    end

`ifdef NV_FIFO_CTL_BYPASS_EN
    localparam int EXP_LAT = 1;
    localparam int BYP     = 1;
`else
    localparam int EXP_LAT = 3;
    localparam int BYP     = 0;
`endif

    int          n_run;
    int          n_fail;
    int          delivered;
    logic [15:0] sb_q [$];
    logic        prev_stall;
    logic [15:0] prev_pd;
    logic        last_acc, last_rd_pvld, last_wr_prdy;
    logic        last_we, last_re, last_ore, last_byp;
    logic [15:0] last_rd_pd;
    logic [4:0]  last_occ;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample and check at negedge, commit the reference model at posedge.
    task automatic cycle();
        logic dlv;
        @(negedge clk);
        last_rd_pvld = rd_pvld;
        last_rd_pd   = rd_pd;
        last_wr_prdy = wr_prdy;
        last_we      = ram_we;
        last_re      = ram_re;
        last_ore     = ram_ore;
        last_byp     = ram_byp_sel;
        last_occ     = occ;
        if (!rst) begin
            check("occ", 32'(occ), sb_q.size());
            if (sb_q.size() < 20) check("wr_prdy_free", 32'(wr_prdy), 1);
            if (prev_stall) begin
                check("stall_vld", 32'(rd_pvld), 1);
                check("stall_pd", 32'(rd_pd), 32'(prev_pd));
            end
            if (rd_pvld) begin
                if (sb_q.size() == 0) check("rd_spurious", 32'(rd_pvld), 0);
                else                  check("rd_order", 32'(rd_pd), 32'(sb_q[0]));
            end
            if (ram_we && ram_re) check("ram_collision", 32'(ram_wa == ram_ra), 0);
            if (ram_we) check("ram_wa_range", 32'(ram_wa < 5'd20), 1);
        end
        last_acc   = wr_pvld & wr_prdy & !rst;
        dlv        = rd_pvld & rd_prdy & !rst;
        prev_stall = rd_pvld & !rd_prdy & !rst;
        prev_pd    = rd_pd;
        @(posedge clk);
        if (rst) begin
            sb_q.delete();
        end else begin
            if (dlv && sb_q.size() > 0) begin
                void'(sb_q.pop_front());
                delivered++;
            end
            if (last_acc) sb_q.push_back(wr_pd);
        end
        #1;
    endtask

    task automatic drain(input int budget);
        wr_pvld = 1'b0;
        rd_prdy = 1'b1;
        for (int c = 0; c < budget && sb_q.size() > 0; c++) cycle();
        check("drained", sb_q.size(), 0);
    endtask

    initial begin
        int lat;
        int n;
        int d0;
        int first;
        int last;
        n_run = 0; n_fail = 0; delivered = 0; prev_stall = 1'b0;
        rst = 1'b1; wr_pvld = 1'b1; rd_prdy = 1'b1; wr_pd = 16'h1111;
        pwrbus_ram_pd = 32'hCAFE_0123;

        // Reset holds every strobe low even with wr_pvld asserted.
        repeat (3) cycle();
        check("rst_wr_prdy", 32'(last_wr_prdy), 0);
        check("rst_rd_pvld", 32'(last_rd_pvld), 0);
        check("rst_occ", 32'(last_occ), 0);
        check("rst_we", 32'(last_we), 0);
        check("rst_re", 32'(last_re), 0);
        check("rst_ore", 32'(last_ore), 0);
        check("rst_byp", 32'(last_byp), 0);
        check("pwrbus", ram_pwrbus_pd, 32'hCAFE_0123);
        rst = 1'b0; wr_pvld = 1'b0;
        cycle();
        check("rel_wr_prdy", 32'(last_wr_prdy), 1);

        // Single word latency.
        wr_pvld = 1'b1; wr_pd = 16'h1234;
        cycle();
        wr_pvld = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            cycle();
            if (BYP == 0 && i == 1) check("lat_re_t1", 32'(last_re), 1);
            if (BYP == 0 && i == 2) check("lat_ore_t2", 32'(last_ore), 1);
            if (last_rd_pvld) lat = i;
        end
        check("lat_single", lat, EXP_LAT);
        check("lat_pd", 32'(last_rd_pd), 32'h1234);
        repeat (2) cycle();

        // Fill with output stalled: 22 words fit, then wr_prdy drops.
        rd_prdy = 1'b0; wr_pvld = 1'b1; n = 0;
        for (int c = 0; c < 80 && n < 22; c++) begin
            wr_pd = 16'(n);
            cycle();
            if (last_acc) n++;
        end
        check("fill_count", n, 22);
        wr_pd = 16'hDEAD;
        cycle();
        check("full_wr_prdy", 32'(last_wr_prdy), 0);
        check("full_occ", 32'(last_occ), 22);
        d0 = delivered;
        drain(60);
        check("fill_drain_cnt", delivered - d0, 22);

        // Continuous stream of 50 words: no bubbles once the pipeline is primed.
        rd_prdy = 1'b1; n = 0; first = -1; last = -1; d0 = delivered;
        for (int c = 0; c < 200 && delivered - d0 < 50; c++) begin
            wr_pvld = (n < 50);
            wr_pd   = 16'(16'h100 + n);
            cycle();
            if (last_acc) n++;
            if (last_rd_pvld) begin
                if (first < 0) first = c;
                last = c;
            end
        end
        check("stream_count", delivered - d0, 50);
        check("stream_no_bubble", last - first + 1, 50);

        // Random traffic with backpressure.
        for (int c = 0; c < 400; c++) begin
            wr_pvld = 1'($urandom_range(0, 1));
            wr_pd   = 16'($urandom);
            rd_prdy = ($urandom_range(0, 99) < 45);
            cycle();
        end
        drain(60);

        // Reset mid-operation discards contents.
        rd_prdy = 1'b0; wr_pvld = 1'b1; n = 0;
        for (int c = 0; c < 40 && n < 10; c++) begin
            wr_pd = 16'(16'h700 + n);
            cycle();
            if (last_acc) n++;
        end
        wr_pvld = 1'b0;
        cycle();
        check("pre_rst_occ", 32'(last_occ), 10);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        check("post_rst_occ", 32'(last_occ), 0);
        check("post_rst_rd_pvld", 32'(last_rd_pvld), 0);
        check("post_rst_wr_prdy", 32'(last_wr_prdy), 1);
        wr_pvld = 1'b1; wr_pd = 16'hBEEF; rd_prdy = 1'b1;
        cycle();
        wr_pvld = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            cycle();
            if (last_rd_pvld) lat = i;
        end
        check("beef_first", 32'(last_rd_pd), 32'hBEEF);
        repeat (2) cycle();

        // Write into an otherwise empty block while the held output word is taken.
        rd_prdy = 1'b0; wr_pvld = 1'b1; wr_pd = 16'h5A5A;
        cycle();
        wr_pvld = 1'b0;
        repeat (5) cycle();
        check("byp_pre_vld", 32'(last_rd_pvld), 1);
        rd_prdy = 1'b1; wr_pvld = 1'b1; wr_pd = 16'hA5A5;
        cycle();
        check("byp_sel", 32'(last_byp), BYP);
        check("byp_we", 32'(last_we), 1 - BYP);
        wr_pvld = 1'b0;
        cycle();
        check("byp_t1_vld", 32'(last_rd_pvld), BYP);
        if (BYP == 1) check("byp_t1_pd", 32'(last_rd_pd), 32'hA5A5);
        drain(20);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/nv_fifo_ctl_20x16.md
NV_FIFO_CTL_20X16 -- requirements
Module: nv_fifo_ctl_20x16

Interface
REQ-001 SHALL have parameter DEPTH, default 20, meaning RAM entry count (fixed to match the 20x16 RAM).
REQ-002 SHALL have parameter WIDTH, default 16, meaning payload bits.
REQ-003 SHALL have port clk  input  1  single core clock, all logic on posedge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_pvld  input  1  upstream word valid.
REQ-006 SHALL have port wr_prdy  output  1  block accepts a word this cycle.
REQ-007 SHALL have port wr_pd  input  16  upstream payload.
REQ-008 SHALL have port rd_pvld  output  1  downstream word valid.
REQ-009 SHALL have port rd_prdy  input  1  downstream accepts.
REQ-010 SHALL have port rd_pd  output  16  downstream payload, wired from ram_dout.
REQ-011 SHALL have port occ  output  5  words held (RAM + read pipeline, 0..22).
REQ-012 SHALL have ports ram_wa/ram_ra (output 5), ram_we/ram_re/ram_ore/ram_byp_sel (output 1), ram_di/ram_dbyp (output 16), ram_dout (input 16), which drive the 20x16 registered-read RAM.
REQ-013 SHALL have port pwrbus_ram_pd  input  32  passed unchanged to output ram_pwrbus_pd (output 32).

Function
REQ-014 SHALL keep wr_ptr and rd_ptr (5 bits, 0..19), each wrapping 19->0, and cnt (0..20) counting words written but not yet address-issued.
REQ-015 SHALL drive wr_prdy = (cnt < 20) and !rst; ram_we = wr_pvld & wr_prdy & !bypass_take; ram_wa = wr_ptr; ram_di = wr_pd.
REQ-016 SHALL model the two RAM read stages with valid bits s1_vld (address latched in RAM) and s2_vld (RAM output register holds data); rd_pvld = s2_vld.
REQ-017 SHALL drive ram_ore = (s1_vld | bypass_take) & (!s2_vld | rd_prdy); a stalled s2 holds the RAM output register.
REQ-018 SHALL drive ram_re = (cnt > 0) & (!s1_vld | ram_ore); ram_ra = rd_ptr; with ram_re low the latched address holds.
REQ-019 SHALL update cnt by +ram_we -ram_re in the same cycle; simultaneous write and read-issue at cnt 20 or cnt 0 SHALL be handled (write at 20 blocked; re at 0 never issued).
REQ-020 SHALL make a word written at cycle t eligible for ram_re no earlier than t+1 (no same-cycle write/read of one entry).
REQ-021 SHALL give non-bypass latency: wr accept at t -> ram_re at t+1 -> ram_ore at t+2 -> rd_pvld at t+3, with no bubbles under continuous flow.
REQ-022 SHALL hold occ = cnt + s1_vld + s2_vld, and rd_pd stable while rd_pvld & !rd_prdy.
REQ-023 SHALL never drop, duplicate or reorder words across pointer wrap-around or under backpressure.

Reset
REQ-024 SHALL, while rst is high at posedge, clear wr_ptr, rd_ptr, cnt, s1_vld, s2_vld; outputs wr_prdy=0, rd_pvld=0, occ=0, ram_we=ram_re=ram_ore=ram_byp_sel=0.
REQ-025 SHALL discard all stored and in-flight words on rst asserted mid-operation; the first cycle after rst deasserts, wr_prdy=1.
REQ-026 SHALL not require RAM contents or the RAM output register to be reset; s2_vld alone qualifies rd_pd.

Configuration
REQ-027 SHALL, with macro NV_FIFO_CTL_BYPASS_EN defined, set bypass_take = wr_pvld & (cnt==0) & !s1_vld & (!s2_vld | rd_prdy), driving ram_byp_sel=1, ram_dbyp=wr_pd, ram_ore=1, ram_we=0, giving rd_pvld at t+1.
REQ-028 SHALL, without NV_FIFO_CTL_BYPASS_EN, tie bypass_take=0, ram_byp_sel=0, ram_dbyp=0.

Verification
REQ-029 SHALL cover: single write 0x1234 at t, rd_prdy=1 -> rd_pvld=1, rd_pd=0x1234 at t+3 (t+1 with bypass macro).
REQ-030 SHALL cover: rd_prdy=0, write 22 words 0..21 -> wr_prdy low after the 22nd accept, occ=22; release rd_prdy -> words 0..21 in order.
REQ-031 SHALL cover: 50 words with continuous wr_pvld/rd_prdy=1 -> one word per cycle out after fill, pointers wrap twice, data in order.
REQ-032 SHALL cover: random rd_prdy toggling with stall while rd_pvld=1 -> rd_pd unchanged until accepted.
REQ-033 SHALL cover: rst pulsed with occ=10 -> next cycle occ=0, rd_pvld=0; new write 0xBEEF emerges first.
REQ-034 SHALL cover: bypass macro, empty block, write at same cycle rd_pvld&rd_prdy -> ram_byp_sel=1, ram_we=0, word out at t+1.
